async_fifo_rd_ctrl: RTL and testbench

- Read-domain controller of the dual-clock FIFO between the BT.656 capture domain and the Avalon-ST output domain.
- Consumes the write-side Gray pointer produced by the write-domain Gray/binary counter and synchronizes it into the read clock.
- Maintains the read pointer, drives the dual-port RAM read port (1-cycle registered read) and presents data on an Avalon-ST source through a 2-entry output buffer.
- Returns its own Gray read pointer to the write domain for full detection.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/gray_sync.sv | 31 +++
 rtl/async_fifo_rd_ctrl.sv | 127 ++++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer types and Gray/binary helpers for the dual-clock FIFO
package fifo_pkg;

    // Default FIFO address width; ptr_t carries one extra wrap bit.
    localparam int FIFO_ADDR_WIDTH = 3;

    // Occupancy limit of the read-side output buffer.
    localparam int OUT_BUF_DEPTH = 2;

    // Widest pointer the helpers accept; narrower pointers are zero-extended.
    localparam int GRAY_W = 32;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    // Zero-extension of a narrower operand does not change the result bits.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extended upper bits contribute nothing to the narrow result.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin = gray;
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop vector synchronizer for Gray-coded pointers
module gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Shift the asynchronous Gray vector through the flop chain; only one bit
    // changes per pointer step, so any sampled value is old or new, never mixed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - read-domain controller of the dual-clock FIFO with streaming output buffer
module async_fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_gray_in,
    output logic [ADDR_WIDTH:0]   rd_gray_out,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  src_valid,
    output logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_ready,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  level_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [PTR_W-1:0]      wr_gray_sync;
    logic [PTR_W-1:0]      wr_bin;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      level_diff;
    logic                  pend;
    logic                  empty;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ_after_pop;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_mem [OUT_BUF_DEPTH];

    gray_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clock (clock),
        .reset (reset),
        .din   (wr_gray_in),
        .dout  (wr_gray_sync)
    );

    // Decode the synchronized write pointer and decide whether to issue a RAM read.
    // A read is issued only if the word it returns is guaranteed a buffer slot,
    // counting the read already in flight and any word leaving this cycle.
    always_comb begin
        wr_bin        = PTR_W'(gray2bin(GRAY_W'(wr_gray_sync)));
        empty         = (wr_bin == rd_ptr);
        pop           = src_valid && src_ready;
        occ_after_pop = 3'(buf_cnt) + 3'(pend) - 3'(pop);
        issue         = !empty && (occ_after_pop < 3'(OUT_BUF_DEPTH));
        level_diff    = wr_bin - rd_ptr;
    end

    assign ram_rd_en   = issue;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign src_valid   = (buf_cnt != 2'd0);
    assign src_data    = buf_mem[0];

    // Advance the read pointer on issue, track the in-flight read, and publish the
    // Gray pointer one cycle later; the slot is released at issue because the RAM
    // read completes before the writer can observe the new pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            rd_gray_out <= '0;
            pend        <= 1'b0;
        end else begin
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            rd_gray_out <= PTR_W'(bin2gray(GRAY_W'(rd_ptr)));
            pend        <= issue;
        end
    end

    // Two-entry output buffer: entry 0 is the head presented on the source port;
    // capture and pop in the same cycle keep the count and the word order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_cnt    <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            case ({pend, pop})
                2'b01: begin
                    buf_mem[0] <= buf_mem[1];
                    buf_cnt    <= buf_cnt - 2'd1;
                end
                2'b10: begin
                    buf_mem[buf_cnt[0]] <= ram_rd_data;
                    buf_cnt             <= buf_cnt + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_mem[0] <= ram_rd_data;
                    end else begin
                        buf_mem[0] <= buf_mem[1];
                        buf_mem[1] <= ram_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register the unissued-entry count; a distance beyond DEPTH can only come from
    // a corrupted or multi-bit-changed Gray input and is latched until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_level <= '0;
            level_err  <= 1'b0;
        end else begin
            fill_level <= level_diff;
            if (level_diff > PTR_W'(DEPTH)) begin
                level_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - self-checking bench for the FIFO read-domain controller
module tb_async_fifo_rd_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] wr_gray_in;
    logic [PW-1:0] rd_gray_out;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic [PW-1:0] fill_level;
    logic          level_err;

    int checks = 0;
    int passes = 0;
    int iss_cnt = 0;
    int span;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] wr_ptr;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_gray_in  (wr_gray_in),
        .rd_gray_out (rd_gray_out),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .fill_level  (fill_level),
        .level_err   (level_err)
    );

    always #5 clock = ~clock;

    // Dual-port RAM read port with one-cycle registered read.
    always @(posedge clock) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            logic acc;
            acc = 1'b0;
            for (int j = i; j < PW; j++) acc = acc ^ g[j];
            b[i] = acc;
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every issued read must address the next slot in sequence, wrapping at DEPTH.
    always @(negedge clock) begin
        if (reset) begin
            iss_cnt = 0;
        end else if (ram_rd_en) begin
            check("rd_addr_seq", 32'(ram_rd_addr), 32'(iss_cnt % DEPTH));
            iss_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        src_ready  = 1'b0;
        wr_gray_in = '0;
        wr_ptr     = '0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Writer pushes words whenever the returned read pointer shows space; reader
    // side pops against the reference queue and checks hold-under-backpressure.
    task automatic stream(input int n, input bit rnd, input int budget, output int gap_span);
        int  sent  = 0;
        int  rcvd  = 0;
        int  first = -1;
        int  last  = -1;
        bit  stall = 1'b0;
        logic [DW-1:0] held = '0;
        logic [PW-1:0] rd_seen;
        logic [DW-1:0] w;
        for (int cyc = 0; cyc < budget && rcvd < n; cyc++) begin
            rd_seen = from_gray(rd_gray_out);
            if (sent < n && (wr_ptr - rd_seen) < PW'(DEPTH)) begin
                w = DW'($urandom);
                mem[wr_ptr[AW-1:0]] = w;
                exp_q.push_back(w);
                wr_ptr     = wr_ptr + PW'(1);
                wr_gray_in = to_gray(wr_ptr);
                sent++;
            end
            src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                check("hold_valid", 32'(src_valid), 32'(1));
                check("hold_data", 32'(src_data), 32'(held));
            end
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", 32'(src_valid), 32'(0));
                end else begin
                    check("stream_data", 32'(src_data), 32'(exp_q.pop_front()));
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcvd++;
            end
            stall = src_valid && !src_ready;
            held  = src_data;
            step();
        end
        check("stream_done", 32'(rcvd), 32'(n));
        src_ready = 1'b0;
        gap_span  = last - first;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state and idle with an unchanging write pointer.
        do_reset();
        check("rst_valid", 32'(src_valid), 32'(0));
        check("rst_rd_en", 32'(ram_rd_en), 32'(0));
        check("rst_gray", 32'(rd_gray_out), 32'(0));
        check("rst_fill", 32'(fill_level), 32'(0));
        check("rst_err", 32'(level_err), 32'(0));
        check("rst_data", 32'(src_data), 32'(0));
        repeat (6) begin
            step();
            check("idle_rd_en", 32'(ram_rd_en), 32'(0));
            check("idle_valid", 32'(src_valid), 32'(0));
        end
        check("idle_gray", 32'(rd_gray_out), 32'(0));
        check("idle_fill", 32'(fill_level), 32'(0));

        // Single word: latency through the synchronizer, RAM and buffer.
        mem[0]     = 8'hA5;
        wr_ptr     = PW'(1);
        wr_gray_in = to_gray(wr_ptr);
        src_ready  = 1'b1;
        step();
        check("lat1_rd_en", 32'(ram_rd_en), 32'(0));
        step();
        check("lat2_rd_en", 32'(ram_rd_en), 32'(1));
        check("lat2_addr", 32'(ram_rd_addr), 32'(0));
        check("lat2_valid", 32'(src_valid), 32'(0));
        step();
        check("lat3_rd_en", 32'(ram_rd_en), 32'(0));
        check("lat3_gray", 32'(rd_gray_out), 32'(0));
        check("lat3_fill", 32'(fill_level), 32'(1));
        check("lat3_valid", 32'(src_valid), 32'(0));
        step();
        check("lat4_valid", 32'(src_valid), 32'(1));
        check("lat4_data", 32'(src_data), 32'(8'hA5));
        check("lat4_gray", 32'(rd_gray_out), 32'(4'b0001));
        check("lat4_fill", 32'(fill_level), 32'(0));
        step();
        check("lat5_valid", 32'(src_valid), 32'(0));

        // Eight words written at once under backpressure, then drained.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
            exp_q.push_back(mem[i]);
        end
        wr_ptr     = PW'(8);
        wr_gray_in = to_gray(wr_ptr);
        repeat (10) step();
        check("bp_issued", 32'(iss_cnt), 32'(2));
        check("bp_valid", 32'(src_valid), 32'(1));
        check("bp_data", 32'(src_data), 32'(exp_q[0]));
        check("bp_fill", 32'(fill_level), 32'(6));
        check("bp_err", 32'(level_err), 32'(0));
        src_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", 32'(src_valid), 32'(1));
            check("drain_data", 32'(src_data), 32'(exp_q.pop_front()));
            step();
        end
        check("drain_end", 32'(src_valid), 32'(0));
        src_ready = 1'b0;

        // Continuous streaming across both address and pointer wrap.
        do_reset();
        stream(40, 1'b0, 400, span);
        check("no_gaps", 32'(span), 32'(39));
        repeat (4) step();
        check("wrap_valid", 32'(src_valid), 32'(0));
        check("wrap_fill", 32'(fill_level), 32'(0));
        check("wrap_gray", 32'(rd_gray_out), 32'(to_gray(wr_ptr)));
        check("wrap_issued", 32'(iss_cnt), 32'(40));

        // Randomized ready with the reference queue as scoreboard.
        stream(200, 1'b1, 4000, span);
        repeat (4) step();
        check("rand_idle", 32'(src_valid), 32'(0));
        check("rand_issued", 32'(iss_cnt), 32'(240));

        // Corrupt pointer distance latches level_err; reset mid-transfer clears all.
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        wr_gray_in = to_gray(PW'(12));
        repeat (8) step();
        check("err_set", 32'(level_err), 32'(1));
        check("err_fill", 32'(fill_level), 32'(10));
        check("err_issued", 32'(iss_cnt), 32'(2));
        wr_gray_in = to_gray(PW'(2));
        repeat (5) step();
        check("err_sticky", 32'(level_err), 32'(1));
        check("err_fill0", 32'(fill_level), 32'(0));
        check("err_buffered", 32'(src_valid), 32'(1));
        check("err_gray", 32'(rd_gray_out), 32'(to_gray(PW'(2))));
        #2;
        reset      = 1'b1;
        wr_gray_in = '0;
        #1;
        check("arst_valid", 32'(src_valid), 32'(0));
        check("arst_err", 32'(level_err), 32'(0));
        check("arst_gray", 32'(rd_gray_out), 32'(0));
        check("arst_addr", 32'(ram_rd_addr), 32'(0));
        check("arst_fill", 32'(fill_level), 32'(0));
        check("arst_rd_en", 32'(ram_rd_en), 32'(0));
        check("arst_data", 32'(src_data), 32'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) step();
        check("post_valid", 32'(src_valid), 32'(0));
        check("post_err", 32'(level_err), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
